// File: rtl/bbs32_seq_pkg.sv
// rtl/bbs32_seq_pkg.sv - shared types and widths for the bbs32 request sequencer
package bbs32_seq_pkg;

  localparam int WORD_W = 32;
  localparam int MOD_W  = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RES,
    ST_RELEASE,
    ST_CAPTURE
  } state_t;

  typedef enum logic {
    CFG_FULL   = 1'b0,
    CFG_RESEED = 1'b1
  } cfg_mode_t;

endpackage

// File: rtl/bbs32_seq_fifo.sv
// rtl/bbs32_seq_fifo.sv - synchronous word FIFO with flush; head is zero while empty
module bbs32_seq_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int W          = 32
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          flush,
  input  logic                          push,
  input  logic [W-1:0]                  push_data,
  input  logic                          pop,
  output logic [W-1:0]                  head,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Flush wins over a same-cycle push or pop: the old sequence is discarded whole.
  always_ff @(posedge clk) begin
    if (!nrst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bbs32_seq.sv
// rtl/bbs32_seq.sv - bbs32 request sequencer with output FIFO; BBS32_SEQ_MCHECK_EN adds modulus check
module bbs32_seq
  import bbs32_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_LIMIT = 4096
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_mode,
  input  logic [WORD_W-1:0] cfg_p,
  input  logic [WORD_W-1:0] cfg_q,
  input  logic [WORD_W-1:0] cfg_seed,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic [WORD_W-1:0] rnd_data,
  output logic [WORD_W-1:0] bbs_p,
  output logic [WORD_W-1:0] bbs_q,
  output logic [WORD_W-1:0] bbs_seed,
  output logic              bbs_start,
  output logic              bbs_keep_m,
  output logic              bbs_use_xnext,
  input  logic [MOD_W-1:0]  bbs_m,
  input  logic              bbs_m_valid,
  input  logic [WORD_W-1:0] bbs_result,
  input  logic              bbs_result_valid,
  output logic              busy,
  output logic              err_timeout
`ifdef BBS32_SEQ_MCHECK_EN
  ,
  output logic              err_m
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CW    = $clog2(WAIT_LIMIT + 1);

  state_t            state;
  state_t            state_nxt;
  logic              alive;
  logic              cfg_seen;
  logic              m_loaded;
  logic              first_after_cfg;
  logic              last_full;
  logic [WORD_W-1:0] res_q;
  logic [CW-1:0]     wait_cnt;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              cfg_acc;
  logic              full_load;
  logic              timeout;
  logic              can_issue;
  logic              req_active;

  assign cfg_acc   = cfg_valid & cfg_ready;
  assign full_load = (cfg_mode == CFG_FULL) | ~m_loaded;
  assign timeout   = (state == ST_WAIT_RES) & ~bbs_result_valid & (wait_cnt == CW'(WAIT_LIMIT - 1));
  assign can_issue = en & cfg_seen & ~err_timeout & (fifo_count < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (!nrst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (!cfg_acc && can_issue) state_nxt = ST_ISSUE;
      ST_ISSUE:    state_nxt = ST_WAIT_RES;
      ST_WAIT_RES: begin
        if (bbs_result_valid) state_nxt = ST_RELEASE;
        else if (timeout)     state_nxt = ST_IDLE;
      end
      ST_RELEASE:  state_nxt = ST_CAPTURE;
      ST_CAPTURE:  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Request controls only depend on flags that stay frozen while a request is open.
  always_comb begin
    req_active    = (state == ST_ISSUE) || (state == ST_WAIT_RES);
    bbs_start     = req_active;
    bbs_keep_m    = req_active & ~(first_after_cfg & last_full);
    bbs_use_xnext = req_active & ~first_after_cfg;
    busy          = (state != ST_IDLE);
    cfg_ready     = (state == ST_IDLE) & alive;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      alive           <= 1'b0;
      cfg_seen        <= 1'b0;
      m_loaded        <= 1'b0;
      first_after_cfg <= 1'b0;
      last_full       <= 1'b0;
      err_timeout     <= 1'b0;
      bbs_p           <= '0;
      bbs_q           <= '0;
      bbs_seed        <= '0;
      res_q           <= '0;
      wait_cnt        <= '0;
    end else begin
      alive <= 1'b1;
      if (cfg_acc) begin
        bbs_seed        <= cfg_seed;
        cfg_seen        <= 1'b1;
        first_after_cfg <= 1'b1;
        err_timeout     <= 1'b0;
        last_full       <= full_load;
        if (full_load) begin
          bbs_p    <= cfg_p;
          bbs_q    <= cfg_q;
          m_loaded <= 1'b0;
        end
      end
      if (state == ST_ISSUE)         wait_cnt <= CW'(1);
      else if (state == ST_WAIT_RES) wait_cnt <= wait_cnt + CW'(1);
      if (state == ST_WAIT_RES && bbs_result_valid) res_q <= bbs_result;
      if (timeout) err_timeout <= 1'b1;
      if (state == ST_CAPTURE) begin
        m_loaded        <= 1'b1;
        first_after_cfg <= 1'b0;
      end
    end
  end

  bbs32_seq_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .W          (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .flush     (cfg_acc),
    .push      (state == ST_CAPTURE),
    .push_data (res_q),
    .pop       (rnd_valid & rnd_ready),
    .head      (rnd_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign rnd_valid = ~fifo_empty;

`ifdef BBS32_SEQ_MCHECK_EN
  logic [MOD_W-1:0] m_expect;
  logic             m_checked;

  assign m_expect = {32'd0, bbs_p} * {32'd0, bbs_q};

  // Only the first valid modulus of a fresh-modulus request is judged.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      err_m     <= 1'b0;
      m_checked <= 1'b0;
    end else begin
      if (cfg_acc) err_m <= 1'b0;
      if (state == ST_IDLE) begin
        m_checked <= 1'b0;
      end else if (bbs_start && !bbs_keep_m && bbs_m_valid && !m_checked) begin
        m_checked <= 1'b1;
        if (bbs_m != m_expect) err_m <= 1'b1;
      end
    end
  end
`else
  logic unused_m;
  assign unused_m = ^{bbs_m, bbs_m_valid};
`endif

endmodule

// File: tb/tb_bbs32_seq.sv
// tb/tb_bbs32_seq.sv - directed bench for bbs32_seq with a scripted bbs32 responder
module tb_bbs32_seq;
  import bbs32_seq_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_mode = 1'b0;
  logic [31:0] cfg_p = '0, cfg_q = '0, cfg_seed = '0;
  logic        rnd_ready = 1'b0;
  logic        cfg_ready, rnd_valid, bbs_start, bbs_keep_m, bbs_use_xnext, busy, err_timeout;
  logic [31:0] rnd_data, bbs_p, bbs_q, bbs_seed;
  logic [63:0] bbs_m;
  logic        bbs_m_valid;
  logic [31:0] bbs_result = '0;
  logic        bbs_result_valid = 1'b0;
`ifdef BBS32_SEQ_MCHECK_EN
  logic        err_m;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  int          lat = 0;
  bit          resp_done = 0;
  bit          hang = 0;
  bit          m_bad = 0;
  int          stab_err = 0;
  int          fill_n = 0;
  logic [1:0]  cur_ctl;
  logic [31:0] resp_q[$];
  logic [1:0]  req_log[$];

  always #5 clk = ~clk;

  bbs32_seq #(.FIFO_DEPTH(4), .WAIT_LIMIT(32)) dut (
    .clk(clk), .nrst(nrst), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cfg_p(cfg_p), .cfg_q(cfg_q), .cfg_seed(cfg_seed),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
    .bbs_p(bbs_p), .bbs_q(bbs_q), .bbs_seed(bbs_seed),
    .bbs_start(bbs_start), .bbs_keep_m(bbs_keep_m), .bbs_use_xnext(bbs_use_xnext),
    .bbs_m(bbs_m), .bbs_m_valid(bbs_m_valid),
    .bbs_result(bbs_result), .bbs_result_valid(bbs_result_valid),
    .busy(busy), .err_timeout(err_timeout)
`ifdef BBS32_SEQ_MCHECK_EN
    , .err_m(err_m)
`endif
  );

  assign bbs_m       = ({32'd0, bbs_p} * {32'd0, bbs_q}) ^ {63'd0, m_bad};
  assign bbs_m_valid = bbs_start & ~bbs_keep_m;

  // Responder: logs request controls, answers on the third start-high cycle from a script.
  always @(negedge clk) begin
    if (!nrst) begin
      bbs_result_valid = 1'b0;
      lat = 0;
      resp_done = 0;
    end else begin
      bbs_result_valid = 1'b0;
      if (bbs_start && !resp_done) begin
        if (lat == 0) begin
          cur_ctl = {bbs_keep_m, bbs_use_xnext};
          req_log.push_back(cur_ctl);
        end else if ({bbs_keep_m, bbs_use_xnext} != cur_ctl) begin
          stab_err++;
        end
        lat++;
        if (lat == 3 && !hang) begin
          if (resp_q.size() > 0) begin
            bbs_result = resp_q.pop_front();
          end else begin
            bbs_result = 32'hF111_0000 | 32'(fill_n);
            fill_n++;
          end
          bbs_result_valid = 1'b1;
          resp_done = 1;
        end
      end else if (!bbs_start) begin
        resp_done = 0;
        lat = 0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_cfg(input logic mode, input logic [31:0] p, input logic [31:0] q,
                        input logic [31:0] s, input bit with_pop);
    int n = 0;
    while (!cfg_ready && n < 100) begin
      tick();
      n++;
    end
    check_val("cfg_ready_wait", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_mode  = mode;
    cfg_p     = p;
    cfg_q     = q;
    cfg_seed  = s;
    rnd_ready = with_pop;
    tick();
    cfg_valid = 1'b0;
    rnd_ready = 1'b0;
  endtask

  task automatic pop_word(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!rnd_valid && n < 200) begin
      tick();
      n++;
    end
    check_val({tag, "_valid"}, rnd_valid, 1);
    check_val(tag, rnd_data, exp);
    rnd_ready = 1'b1;
    tick();
    rnd_ready = 1'b0;
  endtask

  task automatic check_req(input string tag, input int idx, input logic [1:0] exp);
    if (idx < req_log.size()) check_val(tag, req_log[idx], exp);
    else check_val({tag, "_missing"}, req_log.size(), idx + 1);
  endtask

  task automatic wait_start(input logic lvl, input string tag);
    int n = 0;
    while (bbs_start !== lvl && n < 200) begin
      tick();
      n++;
    end
    check_val(tag, bbs_start, lvl);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench watchdog");
  end

  initial begin
    int idx;
    int hi;
    repeat (3) tick();
    check_val("rst_start", bbs_start, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_rnd_valid", rnd_valid, 0);
    check_val("rst_cfg_ready", cfg_ready, 0);
    check_val("rst_p", bbs_p, 0);
    nrst = 1'b1;
    tick();
    check_val("idle_cfg_ready", cfg_ready, 1);

    // Full config, prefetch fills the FIFO with no consumer.
    resp_q = '{32'd1848907155, 32'd3861864124, 32'd2925785739, 32'h0BAD_0004, 32'h0BAD_0005};
    do_cfg(CFG_FULL, 32'd29711, 32'd45543, 32'd56686, 0);
    check_val("cfg_p", bbs_p, 29711);
    check_val("cfg_q", bbs_q, 45543);
    check_val("cfg_seed", bbs_seed, 56686);
    en = 1'b1;
    repeat (60) tick();
    check_val("full_reqs", req_log.size(), 4);
    check_val("full_start", bbs_start, 0);
    check_val("full_busy", busy, 0);
    check_req("req0_ctl", 0, 2'b00);
    check_req("req1_ctl", 1, 2'b11);
    check_req("req3_ctl", 3, 2'b11);
    pop_word("w1", 32'd1848907155);
    wait_start(1'b1, "refill_start");
    wait_start(1'b0, "refill_release");
    tick();
    check_val("w2", rnd_data, 32'd3861864124);
    rnd_ready = 1'b1;
    en = 1'b0;
    tick();
    rnd_ready = 1'b0;
    repeat (20) tick();
    check_val("pushpop_reqs", req_log.size(), 5);
    pop_word("w3", 32'd2925785739);
    pop_word("w4", 32'h0BAD_0004);
    pop_word("w5", 32'h0BAD_0005);
    check_val("drained", rnd_valid, 0);

    // Fill with stale words, then reseed with a same-cycle pop.
    en = 1'b1;
    repeat (60) tick();
    en = 1'b0;
    repeat (20) tick();
    check_val("stale_present", rnd_valid, 1);
    resp_q = '{32'd2864200858, 32'd3865842683};
    idx = req_log.size();
    do_cfg(CFG_RESEED, 32'd0, 32'd0, 32'd5665, 1);
    check_val("reseed_flush", rnd_valid, 0);
    check_val("reseed_seed", bbs_seed, 5665);
    check_val("reseed_p_kept", bbs_p, 29711);
    en = 1'b1;
    pop_word("rs1", 32'd2864200858);
    pop_word("rs2", 32'd3865842683);
    check_req("rs_req0_ctl", idx, 2'b10);
    check_req("rs_req1_ctl", idx + 1, 2'b11);
    en = 1'b0;
    repeat (20) tick();

    // Same full config twice restarts the sequence each time.
    resp_q = '{32'd1317898683};
    idx = req_log.size();
    do_cfg(CFG_FULL, 32'd29715, 32'd45547, 32'd56686, 0);
    en = 1'b1;
    pop_word("c1", 32'd1317898683);
    check_req("c1_ctl", idx, 2'b00);
    en = 1'b0;
    repeat (20) tick();
    resp_q = '{32'd1317898683, 32'd2192164605, 32'd2222407496};
    idx = req_log.size();
    do_cfg(CFG_FULL, 32'd29715, 32'd45547, 32'd56686, 0);
    check_val("c2_q", bbs_q, 45547);
    en = 1'b1;
    pop_word("c2a", 32'd1317898683);
    pop_word("c2b", 32'd2192164605);
    pop_word("c2c", 32'd2222407496);
    check_req("c2_ctl0", idx, 2'b00);
    check_req("c2_ctl1", idx + 1, 2'b11);
    check_req("c2_ctl2", idx + 2, 2'b11);
    en = 1'b0;
    repeat (20) tick();

    // Responder never answers: start must drop after exactly WAIT_LIMIT cycles.
    hang = 1;
    do_cfg(CFG_RESEED, 32'd0, 32'd0, 32'd77, 0);
    en = 1'b1;
    wait_start(1'b1, "to_start");
    hi = 0;
    while (bbs_start && hi < 200) begin
      hi++;
      tick();
    end
    check_val("to_cycles", hi, 32);
    check_val("to_err", err_timeout, 1);
    check_val("to_busy", busy, 0);
    check_val("to_idle", cfg_ready, 1);
    idx = req_log.size();
    repeat (20) tick();
    check_val("to_blocked", req_log.size(), idx);
    hang = 0;
    en = 1'b0;
    do_cfg(CFG_RESEED, 32'd0, 32'd0, 32'd78, 0);
    check_val("to_cleared", err_timeout, 0);

    // Reset while a request is open.
    hang = 1;
    en = 1'b1;
    wait_start(1'b1, "rst_mid_start");
    repeat (3) tick();
    nrst = 1'b0;
    tick();
    check_val("rmid_start", bbs_start, 0);
    check_val("rmid_keep", bbs_keep_m, 0);
    check_val("rmid_busy", busy, 0);
    check_val("rmid_valid", rnd_valid, 0);
    check_val("rmid_data", rnd_data, 0);
    check_val("rmid_seed", bbs_seed, 0);
    check_val("rmid_cfg_ready", cfg_ready, 0);
    tick();
    nrst = 1'b1;
    hang = 0;
    en = 1'b0;
    repeat (2) tick();
    resp_q = '{32'd1848907155};
    idx = req_log.size();
    do_cfg(CFG_RESEED, 32'd29711, 32'd45543, 32'd56686, 0);
    check_val("rs_as_full_p", bbs_p, 29711);
    check_val("rs_as_full_q", bbs_q, 45543);
    en = 1'b1;
    pop_word("after_rst", 32'd1848907155);
    check_req("after_rst_ctl", idx, 2'b00);
    en = 1'b0;
    repeat (20) tick();

`ifdef BBS32_SEQ_MCHECK_EN
    check_val("err_m_clean", err_m, 0);
    m_bad = 1;
    do_cfg(CFG_FULL, 32'd29711, 32'd45543, 32'd56686, 0);
    en = 1'b1;
    repeat (30) tick();
    en = 1'b0;
    repeat (20) tick();
    check_val("err_m_set", err_m, 1);
    m_bad = 0;
`endif

    check_val("ctl_stable", stab_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bbs32_seq.md
Name: bbs32_seq

Overview:
- Initiator/sequencer for the bbs32 Blum Blum Shub engine.
- Holds the P/Q/SEED configuration and drives bbs32's start/keep_m/use_xnext request protocol.
- Captures each 32-bit result into a small FIFO and delivers random words to the system over a valid/ready stream.
- Sits between the SoC-side register/stream logic and a bbs32 instance; owns every request bbs32 sees.

Parameters:
- FIFO_DEPTH, 4: output buffer depth in words; power of two, >= 2.
- WAIT_LIMIT, 4096: max cycles bbs_start may stay high without bbs_result_valid before timeout.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- en  in  1  generation enable; prefetch runs while high
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accepted when cfg_valid&cfg_ready
- cfg_mode  in  1  0 = full (new P, Q, SEED), 1 = reseed only (SEED)
- cfg_p, cfg_q, cfg_seed  in  32 each  config values
- rnd_valid  out  1  output word available
- rnd_ready  in  1  consumer accepts
- rnd_data  out  32  random word (FIFO head)
- bbs_p, bbs_q, bbs_seed  out  32 each  registered config to bbs32
- bbs_start, bbs_keep_m, bbs_use_xnext  out  1 each  bbs32 request controls
- bbs_m  in  64  modulus from bbs32
- bbs_m_valid  in  1  modulus valid
- bbs_result  in  32  bbs32 result
- bbs_result_valid  in  1  bbs32 result valid
- busy  out  1  request in flight
- err_timeout  out  1  sticky WAIT_LIMIT expiry

Behaviour:
- Reset (nrst low at an edge):
  - All outputs go to 0; FIFO is emptied.
  - Internal flags m_loaded and first_after_cfg are cleared; FSM goes to IDLE.
  - A reset during an in-flight request abandons it; bbs_start is 0 on the next cycle.
- FSM states: IDLE, ISSUE, WAIT_RES, RELEASE, CAPTURE.
- IDLE:
  - cfg_ready = 1 only in IDLE.
  - Leaves to ISSUE when en=1, at least one config has been accepted, and (FIFO count + 0 in-flight) < FIFO_DEPTH.
- Config accept (IDLE only):
  - Full mode loads bbs_p, bbs_q and bbs_seed.
  - Reseed loads bbs_seed only.
  - Reseed with m_loaded=0 is treated as full mode.
  - Accept flushes the FIFO (stale sequence), sets first_after_cfg=1 and clears err_timeout.
  - Accept beats a same-cycle pop: rnd_valid = 0 on the next cycle.
- ISSUE: drives bbs_start=1 with the controls below, then goes to WAIT_RES.
  - First request after full config: keep_m=0, use_xnext=0.
  - First request after reseed: keep_m=1, use_xnext=0.
  - All later requests: keep_m=1, use_xnext=1.
- WAIT_RES:
  - bbs_start and the controls are held stable.
  - On bbs_result_valid=1, go to RELEASE.
  - If the wait counter reaches WAIT_LIMIT: drop start, set err_timeout, go to IDLE. No push; generation is blocked until the next config.
- RELEASE: bbs_start=0, bbs_keep_m=0, bbs_use_xnext=0 for one cycle.
- CAPTURE:
  - Pushes bbs_result into the FIFO.
  - Sets m_loaded=1 and clears first_after_cfg; returns to IDLE.
  - bbs_start is therefore low for >= 2 cycles between requests.
- FIFO:
  - A request is issued only when a slot is free, so a push never hits a full FIFO.
  - Simultaneous push and pop is legal; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - rnd_data is valid whenever rnd_valid=1 and is held until the handshake.
- busy = 1 in ISSUE, WAIT_RES, RELEASE and CAPTURE.
- en=0 mid-request: the request completes and the word is pushed; no new issue.

Optional Feature:
- Macro BBS32_SEQ_MCHECK_EN.
- When defined:
  - Adds output err_m (1 bit, sticky; reset 0, cleared on config accept).
  - On the first cycle bbs_m_valid=1 during a keep_m=0 request, compares bbs_m with the 64-bit product bbs_p*bbs_q; sets err_m on mismatch.
  - The word is still pushed.
- When undefined: no err_m port and no multiplier.

Decomposition:
- Package bbs32_seq_pkg:
  - state enum typedef.
  - cfg mode enum (CFG_FULL=0, CFG_RESEED=1).
  - word width constant 32 and modulus width 64.
- Sub-module bbs32_seq_fifo: synchronous FIFO with FIFO_DEPTH, push/pop, count, flush.

Test Plan (bench instantiates a real bbs32 alongside the DUT):
- Full config P=29711, Q=45543, SEED=56686, en=1 -> first rnd_data 1848907155 (0x6E341593), then 3861864124 and 2925785739, with correct bbs_keep_m/bbs_use_xnext per request.
- After the above, hold en=0 and rnd_ready=0; pop 3 words; then reseed SEED=5665 in IDLE -> FIFO flushed, next words 2864200858, 3865842683.
- Full config P=29715, Q=45547, SEED=56686 applied twice -> 1317898683 after each; then 2192164605 and 2222407496.
- rnd_ready=0 with FIFO_DEPTH=4 -> exactly 4 words buffered, bbs_start stays 0, busy=0; then pop and push in the same cycle keeps count at 4.
- Stub bbs_result_valid stuck at 0 -> err_timeout=1 after WAIT_LIMIT cycles, bbs_start=0, FSM in IDLE; a new config clears err_timeout.
- Assert nrst mid-WAIT_RES -> on the next edge all outputs are 0 and the FIFO is empty; a new config restarts with keep_m=0. With BBS32_SEQ_MCHECK_EN, a stub driving wrong bbs_m sets err_m.
